router_pkt_engine: RTL

Parametrised packet-ingress datapath for the 1xN router: accepts a byte stream (header, payload, checksum), decodes destination and length from the header, and buffers bytes in a small holding queue. It drains the queue into the selected destination FIFO and checks the trailing checksum in XOR-parity or additive mode. It replaces the externally-sequenced register stage with an internal FSM, a length counter and a HOLD_DEPTH-entry queue that absorbs FIFO back-pressure.

---
 rtl/router_pkt_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/router_pkt_engine.sv
// Packet ingress engine: decodes the header, buffers bytes in a small holding
// queue, drains them to the selected destination FIFO and checks the checksum.
module router_pkt_engine #(
  parameter int DW         = 8,
  parameter int NUM_DEST   = 3,
  parameter int CHK_MODE   = 0,
  parameter int HOLD_DEPTH = 2,
  localparam int AW        = $clog2(NUM_DEST + 1)
) (
  input  logic                router_clock,
  input  logic                resetn,
  input  logic                pkt_valid,
  input  logic [DW-1:0]       data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                busy,
  output logic [DW-1:0]       dout,
  output logic [NUM_DEST-1:0] write_enb,
  output logic [AW-1:0]       dest_id,
  output logic                parity_done,
  output logic                low_pkt_valid,
  output logic                err,
  output logic                drop
);
  localparam int LW = DW - AW;
  localparam int CW = $clog2(HOLD_DEPTH + 1);
  localparam int PW = $clog2(HOLD_DEPTH);
  localparam logic [AW-1:0] DEST_LIMIT = AW'(NUM_DEST);
  localparam logic [CW-1:0] DEPTH_C    = CW'(HOLD_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(HOLD_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

  state_t              state_reg;
  logic [AW-1:0]       dest_id_reg;
  logic [LW-1:0]       len_cnt_reg;
  logic [DW-1:0]       chk_reg;
  logic [DW-1:0]       chk_next;
  logic                parity_done_reg;
  logic                low_pkt_valid_reg;
  logic                err_reg;
  logic                drop_reg;

  logic [DW-1:0]       hold_mem [HOLD_DEPTH];
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [DW-1:0]       dout_reg;
  logic [NUM_DEST-1:0] write_enb_reg;
  logic [NUM_DEST-1:0] write_enb_next;
  logic [2**AW-1:0]    full_ext;

  logic [AW-1:0]       hdr_dest;
  logic [LW-1:0]       hdr_len;
  logic                hdr_ok;
  logic                busy_w;
  logic                accept;
  logic                push;
  logic                pop;

  assign hdr_dest = data_in[AW-1:0];
  assign hdr_len  = data_in[DW-1:AW];
  assign hdr_ok   = hdr_dest < DEST_LIMIT;
  assign busy_w   = (count_reg == DEPTH_C) || (state_reg == CHECK);
  assign accept   = pkt_valid && !busy_w;
  assign push     = accept && ((state_reg == IDLE && hdr_ok) || state_reg == LOAD);

  // Pad the full vector so any dest_id encoding indexes a defined bit.
  assign full_ext = {{(2**AW - NUM_DEST){1'b0}}, fifo_full};
  assign pop      = (count_reg != '0) && !full_ext[dest_id_reg];

  generate
    if (CHK_MODE == 1) begin : g_sum
      assign chk_next = chk_reg + data_in;
    end else begin : g_xor
      assign chk_next = chk_reg ^ data_in;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_wen
      assign write_enb_next[gi] = pop && (dest_id_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge router_clock) begin
    if (push) hold_mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge router_clock) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      dout_reg      <= '0;
      write_enb_reg <= '0;
    end else begin
      write_enb_reg <= write_enb_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
      if (pop) begin
        dout_reg   <= hold_mem[rd_ptr_reg];
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge router_clock) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      dest_id_reg       <= '0;
      len_cnt_reg       <= '0;
      chk_reg           <= '0;
      parity_done_reg   <= 1'b0;
      low_pkt_valid_reg <= 1'b0;
      err_reg           <= 1'b0;
      drop_reg          <= 1'b0;
    end else begin
      drop_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              dest_id_reg       <= hdr_dest;
              chk_reg           <= data_in;
              len_cnt_reg       <= hdr_len;
              parity_done_reg   <= 1'b0;
              low_pkt_valid_reg <= 1'b0;
              err_reg           <= 1'b0;
              state_reg         <= LOAD;
            end else begin
              drop_reg  <= 1'b1;
              state_reg <= DROP;
            end
          end
        end
        LOAD: begin
          // A gap in pkt_valid before the checksum byte means a truncated frame.
          if (!pkt_valid) begin
            low_pkt_valid_reg <= 1'b1;
            err_reg           <= 1'b1;
            parity_done_reg   <= 1'b1;
            state_reg         <= CHECK;
          end else if (accept) begin
            if (len_cnt_reg != '0) begin
              chk_reg     <= chk_next;
              len_cnt_reg <= len_cnt_reg - LW'(1);
            end else begin
              parity_done_reg <= 1'b1;
              err_reg         <= (data_in != chk_reg);
              state_reg       <= CHECK;
            end
          end
        end
        CHECK: begin
          if (count_reg == '0) state_reg <= IDLE;
        end
        DROP: begin
          if (!pkt_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = busy_w;
  assign dout          = dout_reg;
  assign write_enb     = write_enb_reg;
  assign dest_id       = dest_id_reg;
  assign parity_done   = parity_done_reg;
  assign low_pkt_valid = low_pkt_valid_reg;
  assign err           = err_reg;
  assign drop          = drop_reg;
endmodule
